// File: rtl/mgmt_irq_ctrl_if.sv
// CSR port of the management interrupt controller (LiteX CSR bus slice).
interface mgmt_irq_ctrl_if;
  logic [2:0]  csr_adr;
  logic        csr_we;
  logic        csr_re;
  logic [31:0] csr_dat_w;
  logic [31:0] csr_dat_r;

  modport master (output csr_adr, csr_we, csr_re, csr_dat_w, input csr_dat_r);
  modport slave  (input csr_adr, csr_we, csr_re, csr_dat_w, output csr_dat_r);
endinterface

// File: rtl/mgmt_irq_ctrl.sv
// Management-core interrupt controller: per-source sync/latch lanes, fixed
// lowest-index priority, single cpu_irq line, claim/complete over CSR.

// One interrupt source: synchroniser, edge detector and edge-pending latch.
module mgmt_irq_lane #(
  parameter int SYNC_STAGES = 2
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic src,
  input  logic edge_mode,
  input  logic clr,
  output logic pend
);
  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic                   epend;
  logic                   synced;
  logic                   rise;

  assign synced = sync[SYNC_STAGES-1];
  assign rise   = synced & ~prev;

  // Synchroniser chain, plus one flop holding the previous synced level.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync[0] <= src;
      for (int k = 1; k < SYNC_STAGES; k++) sync[k] <= sync[k-1];
      prev <= synced;
    end
  end

  // Edge latch; a rise arriving with a clear wins. Held empty in level mode
  // so switching a source to edge mode never exposes a stale latch.
  always_ff @(posedge sys_clk) begin
    if (sys_rst || !edge_mode) epend <= 1'b0;
    else if (rise)             epend <= 1'b1;
    else if (clr)              epend <= 1'b0;
  end

  // Level sources report the synced level directly, without latching.
  assign pend = edge_mode ? epend : synced;
endmodule

module mgmt_irq_ctrl #(
  parameter int NUM_IRQ     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic [NUM_IRQ-1:0] irq_src,
  mgmt_irq_ctrl_if.slave     csr,
  output logic               cpu_irq,
  output logic [4:0]         active_id
);
  localparam logic [4:0] NO_ID = 5'd31;

  typedef enum logic [1:0] {IDLE, ASSERT, IN_SERVICE} state_t;
  state_t state;

  logic [NUM_IRQ-1:0] enable;
  logic [NUM_IRQ-1:0] edge_sel;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] w1c;
  logic [4:0]         winner;
  logic               any_elig;
  logic               wr_enable, wr_edge, wr_pend;
  logic               rd_claim, claim_fire, cmpl_hit;
  logic [31:0]        dat_r;
  logic               unused_dat_w;

  assign unused_dat_w = ^csr.csr_dat_w;

  assign wr_enable  = csr.csr_we && (csr.csr_adr == 3'd0);
  assign wr_edge    = csr.csr_we && (csr.csr_adr == 3'd1);
  assign wr_pend    = csr.csr_we && (csr.csr_adr == 3'd2);
  assign rd_claim   = csr.csr_re && (csr.csr_adr == 3'd3);
  assign cmpl_hit   = csr.csr_we && (csr.csr_adr == 3'd4) &&
                      (csr.csr_dat_w[4:0] == active_id);
  assign w1c        = wr_pend ? csr.csr_dat_w[NUM_IRQ-1:0] : '0;
  assign eligible   = pending & enable;
  assign any_elig   = |eligible;
  // A claim only takes effect while the request is actually being offered.
  assign claim_fire = rd_claim && (state == ASSERT) && any_elig;

  // Fixed priority: lowest-index eligible source wins.
  always_comb begin
    winner = NO_ID;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) winner = 5'(i);
    end
  end

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_lane
    mgmt_irq_lane #(.SYNC_STAGES(SYNC_STAGES)) u_lane (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .src       (irq_src[g]),
      .edge_mode (edge_sel[g]),
      .clr       (w1c[g] | (claim_fire && (winner == 5'(g)))),
      .pend      (pending[g])
    );
  end

  // ENABLE / EDGE configuration registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      enable   <= '0;
      edge_sel <= '0;
    end else begin
      if (wr_enable) enable   <= csr.csr_dat_w[NUM_IRQ-1:0];
      if (wr_edge)   edge_sel <= csr.csr_dat_w[NUM_IRQ-1:0];
    end
  end

  // Request FSM; cpu_irq follows the ASSERT state one cycle later.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= IDLE;
      cpu_irq   <= 1'b0;
      active_id <= NO_ID;
    end else begin
      cpu_irq <= (state == ASSERT);
      case (state)
        IDLE: if (any_elig) state <= ASSERT;
        ASSERT: begin
          if (!any_elig) begin
            state <= IDLE;
          end else if (rd_claim) begin
            state     <= IN_SERVICE;
            active_id <= winner;
          end
        end
        IN_SERVICE: begin
          if (cmpl_hit) begin
            state     <= IDLE;
            active_id <= NO_ID;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Registered read data, held until the next read strobe.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      dat_r <= '0;
    end else if (csr.csr_re) begin
      case (csr.csr_adr)
        3'd0:    dat_r <= 32'(enable);
        3'd1:    dat_r <= 32'(edge_sel);
        3'd2:    dat_r <= 32'(pending);
        3'd3:    dat_r <= claim_fire ? {27'b0, winner} : 32'hFFFF_FFFF;
        default: dat_r <= '0;
      endcase
    end
  end

  assign csr.csr_dat_r = dat_r;
endmodule
